// File: rtl/parking_meter_if.sv
// ---------------------------------------------------------------------------
// parking_meter_if
//   Bundles the stimulus and status signals of the parking-meter core.
//   The compile-time macro PARKING_METER_FLASH_EN changes only the behaviour
//   of blank_o inside the core. The signal list is the same in both builds.
//
//   Parameters : NUM_COINS, NUM_PRESETS, MAX_COUNT, DIGITS. These must match
//                the values given to the core.
//   Signals    : coin_i    [NUM_COINS]   debounced coin buttons (level)
//                preset_i  [NUM_PRESETS] preset-load requests (level)
//                count_o   [CW]          binary balance
//                bcd_o     [4*DIGITS]    packed BCD balance, digit 0 in [3:0]
//                bcd_valid               1-cycle pulse when bcd_o updates
//                tick_o                  1-cycle pulse per countdown tick
//                expired_o               balance is zero
//                blank_o                 display blank request (flash phase)
//   Modports   : master drives coins/presets (stimulus side),
//                slave is the meter core.
// ---------------------------------------------------------------------------
interface parking_meter_if #(
    parameter int NUM_COINS   = 4,
    parameter int NUM_PRESETS = 2,
    parameter int MAX_COUNT   = 9999,
    parameter int DIGITS      = 4
);
    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [NUM_COINS-1:0]   coin_i;
    logic [NUM_PRESETS-1:0] preset_i;
    logic [CW-1:0]          count_o;
    logic [4*DIGITS-1:0]    bcd_o;
    logic                   bcd_valid;
    logic                   tick_o;
    logic                   expired_o;
    logic                   blank_o;

    modport master (
        output coin_i, preset_i,
        input  count_o, bcd_o, bcd_valid, tick_o, expired_o, blank_o
    );

    modport slave (
        input  coin_i, preset_i,
        output count_o, bcd_o, bcd_valid, tick_o, expired_o, blank_o
    );
endinterface

// File: rtl/parking_meter_core.sv
// ---------------------------------------------------------------------------
// parking_meter_core
//   Parking-meter time accumulator. It provides these functions:
//     - Rising-edge detection on N coin buttons. Each insertion credits its
//       coin value once.
//     - N preset channels that load a fixed balance.
//     - A countdown divider that removes one unit per tick.
//     - Saturation of the balance at MAX_COUNT.
//     - A multi-cycle sequential double-dabble that converts the balance to
//       packed BCD for the seven-segment scanner.
//
//   Optional feature: macro PARKING_METER_FLASH_EN.
//     - Defined: blank_o toggles on every tick while the balance is below
//       FLASH_THRESH. It clears on the next clock once the balance reaches
//       FLASH_THRESH again.
//     - Undefined: blank_o is tied low and no phase register exists.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     bus    parking_meter_if.slave (coin_i, preset_i in; count_o, bcd_o,
//            bcd_valid, tick_o, expired_o, blank_o out)
// ---------------------------------------------------------------------------
module parking_meter_core #(
    parameter int                     NUM_COINS    = 4,
    parameter logic [16*NUM_COINS-1:0] COIN_VALS   = {16'd550, 16'd200, 16'd180, 16'd10},
    parameter int                     NUM_PRESETS  = 2,
    parameter logic [16*NUM_PRESETS-1:0] PRESET_VALS = {16'd205, 16'd10},
    parameter int                     MAX_COUNT    = 9999,
    parameter int                     DIGITS       = 4,
    parameter int                     TICK_DIV     = 100_000_000,
    parameter int                     FLASH_THRESH = 200
) (
    input  logic             clk,
    input  logic             reset,
    parking_meter_if.slave   bus
);
    localparam int CW = $clog2(MAX_COUNT + 1);
    // The arithmetic width leaves headroom for the full balance plus every
    // coin credited in the same cycle, so the sum cannot wrap.
    localparam int AW = CW + 2 + $clog2(NUM_COINS);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(CW) + 1;

    // ------------------------------------------------------------------
    // Coin edge detection
    // ------------------------------------------------------------------
    logic [NUM_COINS-1:0] coin_q_reg;
    logic [NUM_COINS-1:0] coin_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coin_q_reg <= '0;
        end else begin
            coin_q_reg <= bus.coin_i;
        end
    end

    assign coin_pulse = bus.coin_i & ~coin_q_reg;

    // ------------------------------------------------------------------
    // Tick divider: tick_reg is high in the cycle after the wrap to 0
    // ------------------------------------------------------------------
    logic [DW-1:0] div_reg;
    logic          tick_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (div_reg == DW'(TICK_DIV - 1)) begin
            div_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            div_reg  <= div_reg + DW'(1);
            tick_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Balance update
    // ------------------------------------------------------------------
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [AW-1:0] coin_add [NUM_COINS];
    logic [AW-1:0] add_sum;
    logic [AW-1:0] sum_full;
    logic          preset_hit;
    logic [CW-1:0] preset_val;
    logic          dec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COINS; gi++) begin : g_coin
            assign coin_add[gi] = coin_pulse[gi] ? AW'(COIN_VALS[16*gi +: 16]) : '0;
        end
    endgenerate

    assign dec = tick_reg && (count_reg != '0);

    always_comb begin
        add_sum = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            add_sum = add_sum + coin_add[k];
        end
    end

    // The scan runs from the highest index down, so the lowest active
    // preset is the one that remains.
    always_comb begin
        preset_hit = 1'b0;
        preset_val = '0;
        for (int j = NUM_PRESETS - 1; j >= 0; j--) begin
            if (bus.preset_i[j]) begin
                preset_hit = 1'b1;
                preset_val = CW'(PRESET_VALS[16*j +: 16]);
            end
        end
    end

    assign sum_full = AW'(count_reg) - AW'(dec) + add_sum;

    always_comb begin
        count_next = sum_full[CW-1:0];
        if (preset_hit) begin
            count_next = preset_val;
        end else if (sum_full > AW'(MAX_COUNT)) begin
            count_next = CW'(MAX_COUNT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequential double-dabble converter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state_reg;
    logic [CW-1:0]       snap_reg;
    logic [CW-1:0]       bin_reg;
    logic [4*DIGITS-1:0] work_reg;
    logic [4*DIGITS-1:0] work_adj;
    logic [IW-1:0]       iter_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic                bcd_valid_reg;

    // Add 3 to every nibble of 5 or more before each shift.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                       ? work_reg[4*gi +: 4] + 4'd3
                                       : work_reg[4*gi +: 4];
        end
    endgenerate

    // snap_reg records the last value taken for conversion. A difference
    // from the live balance starts a new conversion. Changes made while a
    // conversion runs are picked up when the FSM returns to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            snap_reg      <= '0;
            bin_reg       <= '0;
            work_reg      <= '0;
            iter_reg      <= '0;
            bcd_reg       <= '0;
            bcd_valid_reg <= 1'b0;
        end else begin
            bcd_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (snap_reg != count_reg) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    snap_reg  <= count_reg;
                    bin_reg   <= count_reg;
                    work_reg  <= '0;
                    iter_reg  <= '0;
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    {work_reg, bin_reg} <= {work_adj, bin_reg} << 1;
                    iter_reg <= iter_reg + IW'(1);
                    if (iter_reg == IW'(CW - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bcd_reg       <= work_reg;
                    bcd_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Low-balance flash
    // ------------------------------------------------------------------
`ifdef PARKING_METER_FLASH_EN
    logic phase_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg <= 1'b0;
        end else if (count_reg >= CW'(FLASH_THRESH)) begin
            phase_reg <= 1'b0;
        end else if (tick_reg) begin
            phase_reg <= ~phase_reg;
        end
    end

    assign bus.blank_o = phase_reg;
`else
    assign bus.blank_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count_o   = count_reg;
    assign bus.tick_o    = tick_reg;
    assign bus.expired_o = (count_reg == '0);
    assign bus.bcd_o     = bcd_reg;
    assign bus.bcd_valid = bcd_valid_reg;

endmodule

// File: tb/tb_parking_meter_core.sv
// ---------------------------------------------------------------------------
// tb_parking_meter_core
//   Directed bench for parking_meter_core with TICK_DIV = 8. It keeps a
//   model of the balance, the tick, the flash phase and the BCD display.
//   A compare process checks the DUT against that model on every cycle.
//   Directed steps add literal expectations that pin the model itself.
//   The bench checks blank_o against the same macro as the core.
// ---------------------------------------------------------------------------
module tb_parking_meter_core;
    localparam int TD  = 8;
    localparam int CW  = 14;
    localparam int LAT = 2 * (CW + 3);
`ifdef PARKING_METER_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_meter_if #(.NUM_COINS(4), .NUM_PRESETS(2), .MAX_COUNT(9999), .DIGITS(4)) bus();

    parking_meter_core #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    function automatic int coin_value(input int k);
        case (k)
            0:       return 10;
            1:       return 180;
            2:       return 200;
            default: return 550;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // ---------------- behavioural model ----------------
    int         m_count;
    int         m_n;
    logic       m_tick;
    logic       m_blank;
    logic [3:0] m_coin_prev;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count     = 0;
            m_n         = 0;
            m_tick      = 1'b0;
            m_blank     = 1'b0;
            m_coin_prev = '0;
        end else begin
            int nxt;
            int add;
            if (bus.preset_i[0])      nxt = 10;
            else if (bus.preset_i[1]) nxt = 205;
            else begin
                add = 0;
                for (int k = 0; k < 4; k++)
                    if (bus.coin_i[k] && !m_coin_prev[k]) add += coin_value(k);
                nxt = m_count - ((m_tick && m_count > 0) ? 1 : 0) + add;
                if (nxt > 9999) nxt = 9999;
            end
            if (FLASH) begin
                if (m_count >= 200) m_blank = 1'b0;
                else if (m_tick)    m_blank = ~m_blank;
            end
            m_count     = nxt;
            m_coin_prev = bus.coin_i;
            m_n++;
            m_tick      = (m_n % TD == 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    int          hist[$];
    logic [15:0] last_bcd;

    always @(negedge clk) begin
        if (reset) begin
            hist.delete();
            last_bcd = '0;
        end else begin
            check("count", bus.count_o, m_count);
            check("expired", bus.expired_o, (m_count == 0));
            check("tick", bus.tick_o, m_tick);
            check("blank", bus.blank_o, m_blank);
            hist.push_back(m_count);
            if (hist.size() > LAT + 6) void'(hist.pop_front());
            if (bus.bcd_valid) begin
                bit found = 1'b0;
                pulses++;
                foreach (hist[i]) if (to_bcd(hist[i]) == bus.bcd_o) found = 1'b1;
                compared++;
                if (!found) begin
                    mismatched++;
                    $display("FAIL bcd_conv: got 0x%04h, required BCD of a balance from the last %0d cycles (now %0d)",
                             bus.bcd_o, hist.size(), m_count);
                end
                last_bcd = bus.bcd_o;
            end else begin
                check("bcd_hold", bus.bcd_o, last_bcd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_count", bus.count_o, 0);
        check("rst_expired", bus.expired_o, 1);
        check("rst_bcd", bus.bcd_o, 0);
        check("rst_valid", bus.bcd_valid, 0);
        check("rst_tick", bus.tick_o, 0);
        check("rst_blank", bus.blank_o, 0);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Returns at the negedge of the next tick cycle.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * TD && !seen; i++) begin
            @(negedge clk);
            if (m_tick) seen = 1'b1;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          prev;
        int          p0;
        bit          seen;
        logic [15:0] got_bcd;
        logic        b_exp;

        reset        = 1'b1;
        bus.coin_i   = '0;
        bus.preset_i = '0;

        // 1: idle after reset, no underflow
        do_reset();
        repeat (40) @(negedge clk);
        check("t1_count", bus.count_o, 0);
        check("t1_expired", bus.expired_o, 1);
        check("t1_bcd", bus.bcd_o, 16'h0000);
        check("t1_pulses", pulses, 0);
        $display("t1: idle 40 cycles count=%0d bcd=%04h", bus.count_o, bus.bcd_o);

        // 2: preset 1 loads 205 and converts to BCD, then counts down 3 ticks
        wait_tick();
        bus.preset_i = 2'b10;
        @(negedge clk);
        bus.preset_i = 2'b00;
        check("t2_load", bus.count_o, 205);
        p0   = pulses;
        seen = 1'b0;
        got_bcd = '0;
        for (int i = 2; i <= 25; i++) begin
            @(negedge clk);
            if (bus.bcd_valid && !seen) begin
                seen    = 1'b1;
                got_bcd = bus.bcd_o;
            end
        end
        check("t2_bcd_seen", seen, 1);
        check("t2_bcd", got_bcd, 16'h0205);
        check("t2_pulses", pulses - p0, 1);
        check("t2_after3", bus.count_o, 202);
        $display("t2: preset 205 bcd=%04h count after 3 ticks=%0d", got_bcd, bus.count_o);

        // 3: held coin credits once; coins 0 and 3 rising in a tick cycle
        do_reset();
        @(negedge clk);
        bus.coin_i = 4'b0001;
        @(negedge clk);
        check("t3_hold_first", bus.count_o, 10);
        repeat (29) @(negedge clk);
        bus.coin_i = 4'b0000;
        @(negedge clk);
        wait_tick();
        prev = m_count;
        bus.coin_i = 4'b1001;
        @(negedge clk);
        bus.coin_i = 4'b0000;
        check("t3_tick_coins", bus.count_o, prev - ((prev > 0) ? 1 : 0) + 560);
        $display("t3: coins 0+3 at tick, %0d -> %0d", prev, bus.count_o);

        // 4: saturation at 9999
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            bus.coin_i = 4'b1000;
            @(negedge clk);
            bus.coin_i = 4'b0000;
            if (m_count == 9999) seen = 1'b1;
        end
        check("t4_sat_reached", seen, 1);
        check("t4_sat", bus.count_o, 9999);
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            bus.coin_i = 4'b0001;
            @(negedge clk);
            bus.coin_i = 4'b0000;
            check("t4_hold_sat", bus.count_o, 9999);
        end
        check("t4_bcd", bus.bcd_o, 16'h9999);
        wait_tick();
        @(negedge clk);
        bus.coin_i = 4'b1000;
        @(negedge clk);
        bus.coin_i = 4'b0000;
        check("t4_extra_coin", bus.count_o, 9999);
        wait_tick();
        @(negedge clk);
        check("t4_tick_dec", bus.count_o, 9998);
        $display("t4: saturated, after tick count=%0d bcd=%04h", bus.count_o, bus.bcd_o);

        // 5: preset priority over coins; reset mid-conversion
        @(negedge clk);
        bus.preset_i = 2'b11;
        bus.coin_i   = 4'b0010;
        @(negedge clk);
        bus.preset_i = 2'b00;
        bus.coin_i   = 4'b0000;
        check("t5_preset_prio", bus.count_o, 10);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_bcd", bus.bcd_o, 0);
        check("t5_rst_count", bus.count_o, 0);
        check("t5_rst_valid", bus.bcd_valid, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        p0 = pulses;
        repeat (40) @(negedge clk);
        check("t5_idle_pulses", pulses - p0, 0);
        check("t5_idle_bcd", bus.bcd_o, 0);
        $display("t5: preset 2'b11 gave 10; reset mid-conversion bcd=%04h", bus.bcd_o);

        // 6: low-balance flash
        wait_tick();
        bus.preset_i = 2'b10;
        @(negedge clk);
        bus.preset_i = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (m_count == 199) seen = 1'b1;
        end
        check("t6_reach199", seen, 1);
        check("t6_count199", bus.count_o, 199);
        check("t6_blank_start", bus.blank_o, 0);
        b_exp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            @(negedge clk);
            b_exp = FLASH ? ~b_exp : 1'b0;
            check("t6_blank_toggle", bus.blank_o, b_exp);
        end
        bus.coin_i = 4'b0100;
        @(negedge clk);
        bus.coin_i = 4'b0000;
        check("t6_blank_hold", bus.blank_o, FLASH);
        @(negedge clk);
        check("t6_blank_clear", bus.blank_o, 0);
        $display("t6: flash=%0d count=%0d blank=%0d", FLASH, bus.count_o, bus.blank_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
